// File: rtl/sao_syntax_bin.sv
// sao_syntax_bin: turns one CTB's SAO decision into the ordered HEVC SAO
// syntax bin stream for the CABAC engine. The stream is merge-left,
// merge-up, then for each enabled component: type, offsets, and either the
// BO sign and band bins or the EO class bins.
//
// Optional build macro SAO_OFFSET_CLIP_EN: when it is defined, offset
// magnitudes are saturated to the TR cMax before binarization. When it is
// not defined, only the low bits of the magnitude are used.
module sao_syntax_bin #(
  parameter int OFF_LEN    = 4,
  parameter int BIT_DEPTH  = 8,
  parameter int N_SAO_TYPE = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      slice_sao_luma_flag,
  input  logic                      slice_sao_chroma_flag,
  input  logic                      isLeftMergeAvail,
  input  logic                      isUpperMergeAvail,
  input  logic [1:0]                sao_mode         [0:1],
  input  logic [N_SAO_TYPE-1:0]     best_sao_type    [0:1],
  input  logic [4:0]                best_typeAuxInfo [0:2],
  input  logic signed [OFF_LEN-1:0] sao_offset       [0:2][0:3],
  output logic                      idle,
  output logic                      bin_valid,
  input  logic                      bin_ready,
  output logic                      bin_val,
  output logic                      bin_bypass,
  output logic                      bin_ctx,
  output logic                      bin_last,
  output logic                      done
);

  localparam int BD_EFF = (BIT_DEPTH < 10) ? BIT_DEPTH : 10;
  localparam int CMAX_I = (1 << (BD_EFF - 5)) - 1;
  localparam int CNT_W  = 5;
  localparam int MW     = (OFF_LEN > CNT_W) ? OFF_LEN : CNT_W;
  localparam logic [CNT_W-1:0] CMAX    = CNT_W'(CMAX_I);
  localparam logic [CNT_W-1:0] CMAX_M1 = CNT_W'(CMAX_I - 1);

  localparam logic [1:0] T_OFF = 2'd0;
  localparam logic [1:0] T_BO  = 2'd1;
  localparam logic [1:0] T_EO  = 2'd2;

  // Component advance (NEXTC) is folded into the transitions, so the
  // registered state always points at a bin-emitting step, IDLE or DONE.
  typedef enum logic [3:0] {
    S_IDLE, S_MRG_L, S_MRG_U, S_TYPE, S_OFFS, S_SIGN, S_BAND, S_EOCL, S_DONE
  } state_t;

  typedef struct packed {
    state_t           st;
    logic [1:0]       comp;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
  } pos_t;

  // Captured CTB parameters, frozen while busy
  logic                      luma_en, chroma_en, up_av;
  logic [1:0]                mode_q [0:1];
  logic [N_SAO_TYPE-1:0]     type_q [0:1];
  logic [4:0]                band_q [0:2];
  logic signed [OFF_LEN-1:0] off_q  [0:2][0:3];

  pos_t pos_q, pos_d, adv, start_pos;

  // View of the component currently being coded
  logic             tsel;
  logic [1:0]       cur_type;
  logic [1:0]       cur_class;
  logic [CNT_W-1:0] mag [0:3];
  logic [CNT_W-1:0] cur_mag;
  logic [3:0]       nz;
  logic             cr_on, cr_on_in, mrg_l_val, mrg_u_val, val_last;

  function automatic pos_t mk_pos(input state_t st, input logic [1:0] comp,
                                  input logic [1:0] idx, input logic [CNT_W-1:0] cnt);
    pos_t p;
    p.st   = st;
    p.comp = comp;
    p.idx  = idx;
    p.cnt  = cnt;
    return p;
  endfunction

  // Non-NEW modes code as OFF in the component loop; type 4 is BO.
  function automatic logic [1:0] type_code(input logic [1:0] m,
                                           input logic [N_SAO_TYPE-1:0] t);
    if (m != 2'd1)                 return T_OFF;
    else if (t == N_SAO_TYPE'(4))  return T_BO;
    else                           return T_EO;
  endfunction

  function automatic logic [CNT_W-1:0] off_mag(input logic signed [OFF_LEN-1:0] v);
    logic [OFF_LEN-1:0] a;
    logic [MW-1:0]      m;
    a = v[OFF_LEN-1] ? -v : v;
    m = MW'(a);
`ifdef SAO_OFFSET_CLIP_EN
    return (m > MW'(CMAX_I)) ? CMAX : CNT_W'(m);
`else
    return CNT_W'(m);
`endif
  endfunction

  // First bin position of the component loop starting at component c0.
  function automatic pos_t comp_entry(input int c0, input logic l_en,
                                      input logic c_en, input logic cr_en);
    pos_t p;
    p = mk_pos(S_DONE, 2'd0, 2'd0, '0);
    for (int c = 2; c >= 0; c--) begin
      if (c >= c0) begin
        if (c == 0 && l_en)               p = mk_pos(S_TYPE, 2'd0, 2'd0, '0);
        else if (c == 1 && c_en)          p = mk_pos(S_TYPE, 2'd1, 2'd0, '0);
        else if (c == 2 && c_en && cr_en) p = mk_pos(S_OFFS, 2'd2, 2'd0, '0);
      end
    end
    return p;
  endfunction

  // Next BO sign bin at or after offset i0, else the band position bins.
  function automatic pos_t sign_entry(input int i0, input logic [3:0] nzm,
                                      input logic [1:0] comp);
    pos_t p;
    p = mk_pos(S_BAND, comp, 2'd0, CNT_W'(4));
    for (int i = 3; i >= 0; i--) begin
      if (i >= i0 && nzm[i]) p = mk_pos(S_SIGN, comp, 2'(i), '0);
    end
    return p;
  endfunction

  // Capture all parameters on an accepted start
  always_ff @(posedge clk) begin
    if (start && idle) begin
      luma_en   <= slice_sao_luma_flag;
      chroma_en <= slice_sao_chroma_flag;
      up_av     <= isUpperMergeAvail;
      mode_q    <= sao_mode;
      type_q    <= best_sao_type;
      band_q    <= best_typeAuxInfo;
      off_q     <= sao_offset;
    end
  end

  // Decode the captured parameters for the component in progress
  always_comb begin
    tsel      = (pos_q.comp != 2'd0);
    cur_type  = type_code(mode_q[tsel], type_q[tsel]);
    cur_class = type_q[tsel][1:0];
    cr_on     = (type_code(mode_q[1], type_q[1]) != T_OFF);
    cr_on_in  = (type_code(sao_mode[1], best_sao_type[1]) != T_OFF);
    mrg_l_val = (mode_q[0] == 2'd2) && (type_q[0] == N_SAO_TYPE'(0));
    mrg_u_val = (mode_q[0] == 2'd2) && (type_q[0] == N_SAO_TYPE'(1));
    for (int i = 0; i < 4; i++) begin
      mag[i] = off_mag(off_q[pos_q.comp][i]);
      nz[i]  = (mag[i] != '0);
    end
    cur_mag  = mag[pos_q.idx];
    val_last = (cur_mag < CMAX) ? (pos_q.cnt == cur_mag) : (pos_q.cnt == CMAX_M1);
  end

  // State register: position in the bin stream
  always_ff @(posedge clk) begin
    if (!rst_n) pos_q <= mk_pos(S_IDLE, 2'd0, 2'd0, '0);
    else        pos_q <= pos_d;
  end

  // Next-state: position after the current bin, start entry, and selection
  always_comb begin
    adv = pos_q;
    case (pos_q.st)
      S_MRG_L: begin
        if (mrg_l_val)  adv = mk_pos(S_DONE, 2'd0, 2'd0, '0);
        else if (up_av) adv = mk_pos(S_MRG_U, 2'd0, 2'd0, '0);
        else            adv = comp_entry(0, luma_en, chroma_en, cr_on);
      end
      S_MRG_U: begin
        if (mrg_u_val) adv = mk_pos(S_DONE, 2'd0, 2'd0, '0);
        else           adv = comp_entry(0, luma_en, chroma_en, cr_on);
      end
      S_TYPE: begin
        if (pos_q.cnt != '0)
          adv = mk_pos(S_OFFS, pos_q.comp, 2'd0, '0);
        else if (cur_type == T_OFF)
          adv = comp_entry(int'(pos_q.comp) + 1, luma_en, chroma_en, cr_on);
        else
          adv.cnt = CNT_W'(1);
      end
      S_OFFS: begin
        if (!val_last)
          adv.cnt = pos_q.cnt + CNT_W'(1);
        else if (pos_q.idx != 2'd3)
          adv = mk_pos(S_OFFS, pos_q.comp, pos_q.idx + 2'd1, '0);
        else if (cur_type == T_BO)
          adv = sign_entry(0, nz, pos_q.comp);
        else if (pos_q.comp != 2'd2)
          adv = mk_pos(S_EOCL, pos_q.comp, 2'd0, CNT_W'(1));
        else
          adv = comp_entry(3, luma_en, chroma_en, cr_on);
      end
      S_SIGN: adv = sign_entry(int'(pos_q.idx) + 1, nz, pos_q.comp);
      S_BAND, S_EOCL: begin
        if (pos_q.cnt != '0) adv.cnt = pos_q.cnt - CNT_W'(1);
        else adv = comp_entry(int'(pos_q.comp) + 1, luma_en, chroma_en, cr_on);
      end
      default: adv = pos_q;
    endcase

    if (!slice_sao_luma_flag && !slice_sao_chroma_flag)
      start_pos = mk_pos(S_DONE, 2'd0, 2'd0, '0);
    else if (isLeftMergeAvail)
      start_pos = mk_pos(S_MRG_L, 2'd0, 2'd0, '0);
    else if (isUpperMergeAvail)
      start_pos = mk_pos(S_MRG_U, 2'd0, 2'd0, '0);
    else
      start_pos = comp_entry(0, slice_sao_luma_flag, slice_sao_chroma_flag, cr_on_in);

    pos_d = pos_q;
    if (idle) begin
      if (start) pos_d = start_pos;
      else        pos_d = mk_pos(S_IDLE, 2'd0, 2'd0, '0);
    end else if (bin_ready) begin
      pos_d = adv;
    end
  end

  // Outputs: bin fields decoded from the current position
  always_comb begin
    idle       = (pos_q.st == S_IDLE) || (pos_q.st == S_DONE);
    done       = (pos_q.st == S_DONE);
    bin_valid  = 1'b0;
    bin_val    = 1'b0;
    bin_bypass = 1'b0;
    bin_ctx    = 1'b0;
    case (pos_q.st)
      S_MRG_L: begin
        bin_valid = 1'b1;
        bin_val   = mrg_l_val;
      end
      S_MRG_U: begin
        bin_valid = 1'b1;
        bin_val   = mrg_u_val;
      end
      S_TYPE: begin
        bin_valid = 1'b1;
        if (pos_q.cnt == '0) begin
          bin_val = (cur_type != T_OFF);
          bin_ctx = 1'b1;
        end else begin
          bin_val    = (cur_type == T_EO);
          bin_bypass = 1'b1;
        end
      end
      S_OFFS: begin
        bin_valid  = 1'b1;
        bin_val    = (pos_q.cnt < cur_mag);
        bin_bypass = 1'b1;
      end
      S_SIGN: begin
        bin_valid  = 1'b1;
        bin_val    = off_q[pos_q.comp][pos_q.idx][OFF_LEN-1];
        bin_bypass = 1'b1;
      end
      S_BAND: begin
        bin_valid  = 1'b1;
        bin_val    = band_q[pos_q.comp][pos_q.cnt[2:0]];
        bin_bypass = 1'b1;
      end
      S_EOCL: begin
        bin_valid  = 1'b1;
        bin_val    = cur_class[pos_q.cnt[0]];
        bin_bypass = 1'b1;
      end
      default: ;
    endcase
    bin_last = bin_valid && (adv.st == S_DONE);
  end

endmodule

// File: tb/tb_sao_syntax_bin.sv
// Directed bench for sao_syntax_bin: merge paths, EO/BO luma, chroma with
// cr reuse, no-bin CTB, back-pressure with ignored start, mid-CTB reset.
module tb_sao_syntax_bin;
  localparam int OFF_LEN    = 4;
  localparam int N_SAO_TYPE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n, start;
  logic                      slice_sao_luma_flag, slice_sao_chroma_flag;
  logic                      isLeftMergeAvail, isUpperMergeAvail;
  logic [1:0]                sao_mode         [0:1];
  logic [N_SAO_TYPE-1:0]     best_sao_type    [0:1];
  logic [4:0]                best_typeAuxInfo [0:2];
  logic signed [OFF_LEN-1:0] sao_offset       [0:2][0:3];
  logic idle, bin_valid, bin_ready, bin_val, bin_bypass, bin_ctx, bin_last, done;

  int n_chk = 0;
  int n_err = 0;

  sao_syntax_bin #(.OFF_LEN(OFF_LEN), .BIT_DEPTH(8), .N_SAO_TYPE(N_SAO_TYPE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .slice_sao_luma_flag(slice_sao_luma_flag), .slice_sao_chroma_flag(slice_sao_chroma_flag),
    .isLeftMergeAvail(isLeftMergeAvail), .isUpperMergeAvail(isUpperMergeAvail),
    .sao_mode(sao_mode), .best_sao_type(best_sao_type),
    .best_typeAuxInfo(best_typeAuxInfo), .sao_offset(sao_offset),
    .idle(idle), .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_val(bin_val),
    .bin_bypass(bin_bypass), .bin_ctx(bin_ctx), .bin_last(bin_last), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg;
    slice_sao_luma_flag   = 1'b1;
    slice_sao_chroma_flag = 1'b1;
    isLeftMergeAvail      = 1'b0;
    isUpperMergeAvail     = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sao_mode[c]      = 2'd0;
      best_sao_type[c] = '0;
    end
    for (int c = 0; c < 3; c++) begin
      best_typeAuxInfo[c] = 5'd0;
      for (int i = 0; i < 4; i++) sao_offset[c][i] = '0;
    end
  endtask

  task automatic set_off(input int c, input int a0, input int a1, input int a2, input int a3);
    sao_offset[c][0] = OFF_LEN'(a0);
    sao_offset[c][1] = OFF_LEN'(a1);
    sao_offset[c][2] = OFF_LEN'(a2);
    sao_offset[c][3] = OFF_LEN'(a3);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Collect bins against expected value string and kind string
  // (m = merge ctx, t = type ctx, b = bypass); optionally stall at bin stall_k.
  task automatic run_bins(input string name, input string vals, input string kinds,
                          input int stall_k);
    int k;
    int cyc;
    int n;
    logic [3:0] snap;
    logic [3:0] ex;
    n   = vals.len();
    k   = 0;
    cyc = 0;
    bin_ready = 1'b1;
    while (k < n && cyc < 300) begin
      if (!bin_valid) begin
        chk($sformatf("%s_valid%0d", name, k), 32'(bin_valid), 32'(1));
        break;
      end
      ex = {vals[k] == "1", kinds[k] == "b", kinds[k] == "t", k == n - 1};
      chk($sformatf("%s_bin%0d", name, k), 32'({bin_val, bin_bypass, bin_ctx, bin_last}), 32'(ex));
      if (k == stall_k) begin
        bin_ready = 1'b0;
        snap = {bin_val, bin_bypass, bin_ctx, bin_last};
        for (int s = 0; s < 5; s++) begin
          if (s == 2) begin
            start = 1'b1;
            isLeftMergeAvail    = 1'b1;
            sao_mode[0]         = 2'd2;
            best_sao_type[0]    = '0;
            slice_sao_luma_flag = 1'b0;
          end
          tick();
          start = 1'b0;
          chk($sformatf("%s_hold%0d", name, s),
              32'({bin_valid, bin_val, bin_bypass, bin_ctx, bin_last, idle}),
              32'({1'b1, snap, 1'b0}));
        end
        bin_ready = 1'b1;
      end
      k++;
      tick();
      cyc++;
    end
    chk($sformatf("%s_nbins", name), k, n);
    chk($sformatf("%s_done", name), 32'({done, idle, bin_valid}), 32'(3'b110));
    tick();
    chk($sformatf("%s_done_once", name), 32'({done, idle}), 32'(2'b01));
    bin_ready = 1'b0;
  endtask

  task automatic cfg_eo_luma;
    clear_cfg();
    sao_mode[0]      = 2'd1;
    best_sao_type[0] = 3'd2;
    set_off(0, 3, 1, -1, -2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin_ready = 1'b0;
    clear_cfg();
    repeat (3) tick();
    chk("rst_out", 32'({idle, bin_valid, bin_val, bin_bypass, bin_ctx, bin_last, done}),
        32'(7'b1000000));
    rst_n = 1'b1;
    tick();
    chk("idle_out", 32'({idle, bin_valid, done}), 32'(3'b100));

    // Both merges available, everything OFF
    clear_cfg();
    isLeftMergeAvail  = 1'b1;
    isUpperMergeAvail = 1'b1;
    pulse_start();
    chk("t1_busy", 32'(idle), 32'(0));
    run_bins("t1", "0000", "mmtt", -1);

    // Merge left taken
    clear_cfg();
    isLeftMergeAvail = 1'b1;
    sao_mode[0]      = 2'd2;
    best_sao_type[0] = 3'd0;
    pulse_start();
    run_bins("t2", "1", "m", -1);

    // Merge up taken after merge left coded as 0
    clear_cfg();
    isLeftMergeAvail  = 1'b1;
    isUpperMergeAvail = 1'b1;
    sao_mode[0]       = 2'd2;
    best_sao_type[0]  = 3'd1;
    pulse_start();
    run_bins("t6", "01", "mm", -1);

    // Luma EO class 2, offsets 3,1,-1,-2, chroma OFF
    cfg_eo_luma();
    pulse_start();
    run_bins("t3", "1111101010110100", "tbbbbbbbbbbbbbbt", -1);

    // Luma BO band 12, offsets 0,-2,7,0; stall 5 cycles with a start pulse
    clear_cfg();
    sao_mode[0]         = 2'd1;
    best_sao_type[0]    = 3'd4;
    best_typeAuxInfo[0] = 5'd12;
    set_off(0, 0, -2, 7, 0);
    pulse_start();
    run_bins("t4", "1001101111111010011000", "tbbbbbbbbbbbbbbbbbbbbt", 8);

    // Chroma only, EO class 1; cr reuses cb type and class
    clear_cfg();
    slice_sao_luma_flag = 1'b0;
    sao_mode[0]         = 2'd1;
    best_sao_type[0]    = 3'd4;
    sao_mode[1]         = 2'd1;
    best_sao_type[1]    = 3'd1;
    set_off(1, 1, 0, 0, -1);
    set_off(2, 2, 2, 1, 0);
    pulse_start();
    run_bins("t5", "1110001001110110100", "tbbbbbbbbbbbbbbbbbb", -1);

    // Both slice flags off: no bins even with merge available
    clear_cfg();
    slice_sao_luma_flag   = 1'b0;
    slice_sao_chroma_flag = 1'b0;
    isLeftMergeAvail      = 1'b1;
    pulse_start();
    run_bins("t7", "", "", -1);

    // Reset mid-CTB, then a fresh CTB
    cfg_eo_luma();
    pulse_start();
    bin_ready = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("t8_rst", 32'({idle, bin_valid, done, bin_last}), 32'(4'b1000));
    rst_n = 1'b1;
    bin_ready = 1'b0;
    tick();
    chk("t8_no_done", 32'({idle, bin_valid, done}), 32'(3'b100));
    pulse_start();
    run_bins("t8", "1111101010110100", "tbbbbbbbbbbbbbbt", -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
